// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// FSM states, opcodes, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, never on FSM state
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        sel = IMM_I;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_B:    sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct fields to the ALU operation select.
// Only the R-type form of funct3=000 with bit 30 set is a subtract.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    logic is_sub;

    assign is_sub = op_b5 & funct7b5;

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller sequencing one RV32I instruction over 3-5 cycles
// through a shared memory, with ready/wait handshake and BNE support.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic MEM_HANDSHAKE = 1'b1,
    parameter logic BRANCH_EXT    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    state_t     state_q, state_d;
    aluop_t     alu_op;
    logic       rdy;
    logic       br_taken;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctl;

    assign rdy      = mem_ready | ~MEM_HANDSHAKE;
    assign br_taken = zero ^ (BRANCH_EXT & funct3[0]);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        unique case (state_q)
            S_FETCH: begin
                ir_write   = rdy;
                pc_update  = rdy;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            // Request stays asserted across wait cycles
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctl)
    );

    // Every output is held low while reset is asserted
    assign PCWrite       = ~reset & (pc_update | (branch & br_taken));
    assign AdrSrc        = ~reset & adr_src;
    assign MemWrite      = ~reset & mem_write;
    assign IRWrite       = ~reset & ir_write;
    assign RegWrite      = ~reset & reg_write;
    assign illegal_instr = ~reset & illegal;
    assign ResultSrc     = reset ? 2'b00 : result_src;
    assign ALUSrcA       = reset ? 2'b00 : src_a;
    assign ALUSrcB       = reset ? 2'b00 : src_b;
    assign ImmSrc        = reset ? 2'b00 : imm_sel(op);
    assign ALUControl    = reset ? 3'b000 : alu_ctl;
    assign state_o       = reset ? 4'b0000 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: reset, vector table, hand sequences for waits,
// branch variants, illegal opcodes, plus random instruction streams.
`timescale 1ns/1ps
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mr2;

    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alc;
    logic [3:0] st;

    logic       pcw2, adr2, mw2, irw2, rw2, ill2;
    logic [1:0] rs2, sa2, sb2, imm2;
    logic [2:0] alc2;
    logic [3:0] st2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] alc;
        logic       ill;
    } out_t;

    out_t act, act2;
    assign act  = {st, pcw, adr, mw, irw, rs, sa, sb, rw, imm, alc, ill};
    assign act2 = {st2, pcw2, adr2, mw2, irw2, rs2, sa2, sb2, rw2, imm2, alc2, ill2};

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw),
        .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb), .RegWrite(rw),
        .ImmSrc(imm), .ALUControl(alc), .illegal_instr(ill),
        .state_o(st)
    );

    multicycle_control_unit #(
        .MEM_HANDSHAKE(1'b0), .BRANCH_EXT(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mr2),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2),
        .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .RegWrite(rw2),
        .ImmSrc(imm2), .ALUControl(alc2), .illegal_instr(ill2),
        .state_o(st2)
    );

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic legal(input logic [6:0] o);
        return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};
    endfunction

    // Expected outputs for one cycle, from the published state table
    function automatic out_t model(input state_t s, input logic rdy,
                                   input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z,
                                   input logic bext);
        out_t e;
        logic [2:0] fn;
        e = '0;
        e.st = s;
        if (o == OP_SW)       e.imm = 2'b01;
        else if (o == OP_B)   e.imm = 2'b10;
        else if (o == OP_JAL) e.imm = 2'b11;
        case (f3)
            3'b000:  fn = (o == OP_R && f7) ? 3'b001 : 3'b000;
            3'b010:  fn = 3'b101;
            3'b110:  fn = 3'b011;
            3'b111:  fn = 3'b010;
            default: fn = 3'b000;
        endcase
        case (s)
            S_FETCH: begin
                e.irw = rdy; e.pcw = rdy; e.sb = 2'b10; e.rs = 2'b10;
            end
            S_DECODE: begin
                e.sa = 2'b01; e.sb = 2'b01; e.ill = !legal(o);
            end
            S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            S_MEMREAD:  e.adr = 1'b1;
            S_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
            S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
            S_EXECUTER: begin e.sa = 2'b10; e.alc = fn; end
            S_EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; e.alc = fn; end
            S_ALUWB:    e.rw = 1'b1;
            S_BRANCH: begin
                e.sa  = 2'b10;
                e.alc = 3'b001;
                e.pcw = (bext && f3[0]) ? !z : z;
            end
            S_JAL: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // One cycle, checking the main DUT and optionally the second one
    task automatic cyc(input string nm, input state_t s, input logic rdy,
                       input logic both);
        mem_ready = rdy;
        @(negedge clk);
        chk(nm, act, model(s, rdy, op, funct3, funct7b5, zero, 1'b1));
        if (both)
            chk({nm, "_ext0"}, act2,
                model(s, 1'b1, op, funct3, funct7b5, zero, 1'b0));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cycles;
        logic [1:0] imm;
        logic       chk3;
        logic [2:0] alc3;
        logic       pcw3;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    task automatic run_table();
        for (int i = 0; i < NV; i++) begin
            int   n;
            logic done;
            op = tbl[i].op; funct3 = tbl[i].f3;
            funct7b5 = tbl[i].f7; zero = tbl[i].z;
            mem_ready = 1'b1;
            n = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                n++;
                if (n == 1) chk($sformatf("tbl%0d_imm", i), imm, tbl[i].imm);
                if (n == 3 && tbl[i].chk3) begin
                    chk($sformatf("tbl%0d_alu", i), alc, tbl[i].alc3);
                    chk($sformatf("tbl%0d_pcw", i), pcw, tbl[i].pcw3);
                end
                @(posedge clk); #1;
                if (st == S_FETCH || n >= 12) done = 1'b1;
            end
            chk($sformatf("tbl%0d_cycles", i), n, tbl[i].cycles);
        end
    endtask

    task automatic run_random(input int count);
        state_t     seq[$];
        logic       rq[$];
        logic [6:0] o;
        int         w;
        int         kind;
        for (int k = 0; k < count; k++) begin
            seq.delete();
            rq.delete();
            kind = $urandom_range(0, 6);
            case (kind)
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_R;
                3: o = OP_I;
                4: o = OP_B;
                5: o = OP_JAL;
                default: begin
                    o = 7'($urandom);
                    while (legal(o)) o = 7'($urandom);
                end
            endcase
            w = $urandom_range(0, 2);
            repeat (w) begin seq.push_back(S_FETCH); rq.push_back(1'b0); end
            seq.push_back(S_FETCH); rq.push_back(1'b1);
            seq.push_back(S_DECODE); rq.push_back(1'($urandom));
            w = $urandom_range(0, 3);
            if (o == OP_LW || o == OP_SW) begin
                seq.push_back(S_MEMADR); rq.push_back(1'($urandom));
                repeat (w) begin
                    seq.push_back(o == OP_LW ? S_MEMREAD : S_MEMWRITE);
                    rq.push_back(1'b0);
                end
                seq.push_back(o == OP_LW ? S_MEMREAD : S_MEMWRITE);
                rq.push_back(1'b1);
                if (o == OP_LW) begin
                    seq.push_back(S_MEMWB); rq.push_back(1'($urandom));
                end
            end else if (o == OP_R || o == OP_I) begin
                seq.push_back(o == OP_R ? S_EXECUTER : S_EXECUTEI);
                rq.push_back(1'($urandom));
                seq.push_back(S_ALUWB); rq.push_back(1'($urandom));
            end else if (o == OP_B) begin
                seq.push_back(S_BRANCH); rq.push_back(1'($urandom));
            end else if (o == OP_JAL) begin
                seq.push_back(S_JAL); rq.push_back(1'($urandom));
                seq.push_back(S_ALUWB); rq.push_back(1'($urandom));
            end
            op = o;
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            for (int i = 0; i < seq.size(); i++) begin
                zero = 1'($urandom);
                cyc("rand", seq[i], rq[i], 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 5, 2'b00, 1'b1, 3'b000, 1'b0};
        tbl[1]  = '{OP_SW,  3'b010, 1'b0, 1'b0, 4, 2'b01, 1'b1, 3'b000, 1'b0};
        tbl[2]  = '{OP_R,   3'b000, 1'b1, 1'b0, 4, 2'b00, 1'b1, 3'b001, 1'b0};
        tbl[3]  = '{OP_R,   3'b000, 1'b0, 1'b0, 4, 2'b00, 1'b1, 3'b000, 1'b0};
        tbl[4]  = '{OP_R,   3'b010, 1'b0, 1'b1, 4, 2'b00, 1'b1, 3'b101, 1'b0};
        tbl[5]  = '{OP_R,   3'b110, 1'b0, 1'b0, 4, 2'b00, 1'b1, 3'b011, 1'b0};
        tbl[6]  = '{OP_R,   3'b111, 1'b1, 1'b0, 4, 2'b00, 1'b1, 3'b010, 1'b0};
        tbl[7]  = '{OP_R,   3'b100, 1'b0, 1'b0, 4, 2'b00, 1'b1, 3'b000, 1'b0};
        tbl[8]  = '{OP_I,   3'b000, 1'b1, 1'b0, 4, 2'b00, 1'b1, 3'b000, 1'b0};
        tbl[9]  = '{OP_B,   3'b000, 1'b0, 1'b1, 3, 2'b10, 1'b1, 3'b001, 1'b1};
        tbl[10] = '{OP_B,   3'b000, 1'b0, 1'b0, 3, 2'b10, 1'b1, 3'b001, 1'b0};
        tbl[11] = '{OP_B,   3'b001, 1'b0, 1'b1, 3, 2'b10, 1'b1, 3'b001, 1'b0};
        tbl[12] = '{OP_B,   3'b001, 1'b0, 1'b0, 3, 2'b10, 1'b1, 3'b001, 1'b1};
        tbl[13] = '{OP_JAL, 3'b000, 1'b0, 1'b0, 4, 2'b11, 1'b1, 3'b000, 1'b1};
        tbl[14] = '{7'h7F,  3'b000, 1'b0, 1'b0, 2, 2'b00, 1'b0, 3'b000, 1'b0};
        tbl[15] = '{7'h37,  3'b000, 1'b0, 1'b0, 2, 2'b00, 1'b0, 3'b000, 1'b0};

        reset = 1'b1; op = OP_SW; funct3 = 3'b111; funct7b5 = 1'b1;
        zero = 1'b1; mem_ready = 1'b1; mr2 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outs", act, 32'd0);
            chk("reset_outs_ext0", act2, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // BNE with zero=1: not taken normally, taken when BRANCH_EXT=0
        op = OP_B; funct3 = 3'b001; zero = 1'b1;
        cyc("post_reset_fetch", S_FETCH, 1'b1, 1'b1);
        cyc("bne_decode", S_DECODE, 1'b1, 1'b1);
        cyc("bne_z1_branch", S_BRANCH, 1'b1, 1'b1);
        zero = 1'b0;
        cyc("bne_z0_fetch", S_FETCH, 1'b1, 1'b1);
        cyc("bne_z0_decode", S_DECODE, 1'b1, 1'b1);
        cyc("bne_z0_branch", S_BRANCH, 1'b1, 1'b1);

        op = 7'b1111111; funct3 = 3'b000;
        cyc("ill_fetch", S_FETCH, 1'b1, 1'b1);
        cyc("ill_decode", S_DECODE, 1'b1, 1'b1);
        op = OP_JAL;
        cyc("jal_fetch", S_FETCH, 1'b1, 1'b1);
        cyc("jal_decode", S_DECODE, 1'b1, 1'b1);
        cyc("jal_jal", S_JAL, 1'b1, 1'b1);
        cyc("jal_aluwb", S_ALUWB, 1'b1, 1'b1);

        run_table();

        // Store stalled three cycles in MEMWRITE
        op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        cyc("sw_fetch", S_FETCH, 1'b1, 1'b0);
        cyc("sw_decode", S_DECODE, 1'b1, 1'b0);
        cyc("sw_memadr", S_MEMADR, 1'b0, 1'b0);
        repeat (3) cyc("sw_wait", S_MEMWRITE, 1'b0, 1'b0);
        cyc("sw_done", S_MEMWRITE, 1'b1, 1'b0);
        cyc("sw_next_fetch_wait", S_FETCH, 1'b0, 1'b0);
        op = OP_I; funct3 = 3'b110;
        cyc("fetch_after_wait", S_FETCH, 1'b1, 1'b0);
        cyc("addi_decode", S_DECODE, 1'b1, 1'b0);
        cyc("ori_exec", S_EXECUTEI, 1'b1, 1'b0);
        cyc("ori_wb", S_ALUWB, 1'b1, 1'b0);

        run_random(60);

        // Reset in the middle of a load discards it
        op = OP_LW; funct3 = 3'b010;
        cyc("lw_fetch", S_FETCH, 1'b1, 1'b0);
        cyc("lw_decode", S_DECODE, 1'b1, 1'b0);
        cyc("lw_memadr", S_MEMADR, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outs", act, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc("midreset_fetch", S_FETCH, 1'b1, 1'b0);
        cyc("midreset_decode", S_DECODE, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
